aes128_iter_core: RTL and testbench

// Iterative, round-per-cycle AES-128 encryption engine with valid/ready handshakes on input and output.

---
 rtl/aes128_iter_core.sv | 192 +++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// MODE selects XOR (standard) or byte-wise modular addition for AddRoundKey.
module aes128_iter_core #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned MODE       = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  localparam int unsigned BW = 128;
  localparam int unsigned CW = 4;

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10 || MODE > 1) begin : g_cfg_check
    $error("aes128_iter_core: NUM_ROUNDS must be 1..10 and MODE 0..1");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BW-1:0] ark(input logic [BW-1:0] s, input logic [BW-1:0] k);
    logic [BW-1:0] r;
    if (MODE == 0) begin
      r = s ^ k;
    end else begin
      for (int i = 0; i < 16; i++) r[8*i +: 8] = s[8*i +: 8] + k[8*i +: 8];
    end
    return r;
  endfunction

  // SubBytes and ShiftRows fused; byte 4c+r sits at row r, column c
  function automatic logic [BW-1:0] sub_shift(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[BW-1-8*(4*c+r) -: 8] = sbox(s[BW-1-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [BW-1:0] mix_cols(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    logic [7:0]    a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[BW-1-32*c  -: 8];
      a1 = s[BW-9-32*c  -: 8];
      a2 = s[BW-17-32*c -: 8];
      a3 = s[BW-25-32*c -: 8];
      o[BW-1-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [BW-1:0] key_exp(input logic [BW-1:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         st_q, st_d;
  logic [BW-1:0]  data_q, data_d;
  logic [BW-1:0]  key_q, key_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  rk, sb;
  logic           in_ready_q, out_valid_q, busy_q;

  // Next-state and datapath for the round engine
  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    key_d  = key_q;
    cnt_d  = cnt_q;
    rk     = key_exp(key_q, rcon(cnt_q));
    sb     = sub_shift(data_q);
    case (st_q)
      IDLE: begin
        if (in_valid) begin
          data_d = ark(in_data, in_key);
          key_d  = in_key;
          cnt_d  = CW'(1);
          st_d   = ROUND;
        end
      end
      ROUND: begin
        key_d = rk;
        if (cnt_q == CW'(NUM_ROUNDS)) begin
          data_d = ark(sb, rk);
          st_d   = DONE;
        end else begin
          data_d = ark(mix_cols(sb), rk);
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      data_q      <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      data_q      <= data_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (st_d == IDLE);
      out_valid_q <= (st_d == DONE);
      busy_q      <= (st_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;
  assign round_cnt = cnt_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Scoreboard bench for aes128_iter_core: three configurations share stimulus,
// each compared against a table-driven reference model.
module tb_aes128_iter_core;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V5_PT  = 128'h4142434445464748494a4b4c4d4e4f54;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         ir [3];
  logic         ov [3];
  logic         by [3];
  logic [127:0] od [3];
  logic [3:0]   rc [3];

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int fire_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_iter_core #(.NUM_ROUNDS(10), .MODE(0)) u_std (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_key(in_key), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .busy(by[0]), .round_cnt(rc[0]));

  aes128_iter_core #(.NUM_ROUNDS(10), .MODE(1)) u_add10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_key(in_key), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .busy(by[1]), .round_cnt(rc[1]));

  aes128_iter_core #(.NUM_ROUNDS(1), .MODE(1)) u_add1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_key(in_key), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .busy(by[2]), .round_cnt(rc[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] x);
    return x[7] ? (8'({x[6:0], 1'b0}) ^ 8'h1b) : 8'({x[6:0], 1'b0});
  endfunction

  // Byte-array reference cipher with running rcon
  function automatic logic [127:0] aes_model(input logic [127:0] d, input logic [127:0] k,
                                             input int mode, input int nr);
    logic [7:0] s [16];
    logic [7:0] w [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rcv;
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = d[127-8*i -: 8];
      w[i] = k[127-8*i -: 8];
      s[i] = (mode != 0) ? 8'(s[i] + w[i]) : (s[i] ^ w[i]);
    end
    rcv = 8'h01;
    for (int r = 1; r <= nr; r++) begin
      tmp[0] = sb(w[13]) ^ rcv;
      tmp[1] = sb(w[14]);
      tmp[2] = sb(w[15]);
      tmp[3] = sb(w[12]);
      for (int i = 0; i < 4; i++) w[i] = w[i] ^ tmp[i];
      for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
      rcv = m2(rcv);
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = sb(s[4*((c+q)%4)+q]);
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = m2(a0) ^ (m2(a1) ^ a1) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ m2(a1) ^ (m2(a2) ^ a2) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ m2(a2) ^ (m2(a3) ^ a3);
          t[4*c+3] = (m2(a0) ^ a0) ^ a1 ^ a2 ^ m2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = (mode != 0) ? 8'(t[i] + w[i]) : (t[i] ^ w[i]);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Per-instance scoreboard: push on accept, pop on output handshake
  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int GM = (g == 0) ? 0 : 1;
    localparam int GN = (g == 2) ? 1 : 10;
    logic [127:0] q[$];
    logic [127:0] exp_v;
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        if (ov[g] && out_ready) begin
          check($sformatf("out%0d_pending", g), 128'(q.size() != 0), 128'd1);
          if (q.size() != 0) begin
            exp_v = q.pop_front();
            check($sformatf("out%0d_data", g), od[g], exp_v);
          end
          if (g == 0) fire_q.push_back(cyc);
        end
        if (in_valid && ir[g]) q.push_back(aes_model(in_data, in_key, GM, GN));
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k);
    @(posedge clk) #1;
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir[0]) break;
    end
    check("send_ready", 128'(ir[0]), 128'd1);
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  task automatic measure(output int l0, output int l1, output int l2, output logic [127:0] ct);
    l0 = -1; l1 = -1; l2 = -1; ct = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ov[0] && l0 < 0) begin l0 = k; ct = od[0]; end
      if (ov[1] && l1 < 0) l1 = k;
      if (ov[2] && l2 < 0) l2 = k;
    end
  endtask

  task automatic wait_ov0(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov[0]) break;
    end
    check(tag, 128'(ov[0]), 128'd1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, l2;
    logic [127:0] ct;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(ir[0]), 128'd1);
    check("rst_out_valid", 128'(ov[0]), 128'd0);
    check("rst_busy", 128'(by[0]), 128'd0);
    check("rst_round_cnt", 128'(rc[0]), 128'd0);
    check("rst_out_data", od[0], 128'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;

    // FIPS-197 vector with latency measurement on all configurations
    send(V1_PT, V1_KEY);
    measure(l0, l1, l2, ct);
    check("v1_lat_std", 128'(l0), 128'd10);
    check("v1_lat_add10", 128'(l1), 128'd10);
    check("v1_lat_add1", 128'(l2), 128'd1);
    check("v1_ct", ct, V1_CT);

    // Back-pressure: result held, stray in_valid ignored
    @(posedge clk) #1;
    out_ready = 1'b0;
    send(V2_PT, V2_KEY);
    wait_ov0("bp_wait_valid");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk) #1;
      in_valid = (i % 4 == 1);
      in_data  = rnd128();
      in_key   = rnd128();
      @(negedge clk);
      check("bp_out_valid", 128'(ov[0]), 128'd1);
      check("bp_out_data", od[0], V2_CT);
      check("bp_in_ready", 128'(ir[0]), 128'd0);
      check("bp_busy", 128'(by[0]), 128'd1);
    end
    @(posedge clk) #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_ready", 128'(ir[0]), 128'd1);
    check("bp_idle_valid", 128'(ov[0]), 128'd0);
    check("bp_idle_cnt", 128'(rc[0]), 128'd0);

    // Asynchronous reset in the middle of a block
    send(V1_PT, V1_KEY);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rc[0] == 4'd5) break;
    end
    check("rst_mid_at5", 128'(rc[0]), 128'd5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 128'(ov[0]), 128'd0);
    check("rst_mid_busy", 128'(by[0]), 128'd0);
    check("rst_mid_cnt", 128'(rc[0]), 128'd0);
    check("rst_mid_busy_add10", 128'(by[1]), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(V1_PT, V1_KEY);
    wait_ov0("rst_after_valid");
    check("rst_after_ct", od[0], V1_CT);
    repeat (2) @(negedge clk);

    // Modular-add AddRoundKey, full and single-round
    send(V5_PT, V1_KEY);
    measure(l0, l1, l2, ct);
    check("m1_lat_add10", 128'(l1), 128'd10);
    check("m1_lat_add1", 128'(l2), 128'd1);
    check("m1_ct_std", ct, aes_model(V5_PT, V1_KEY, 0, 10));

    // Streaming with both handshakes held high
    fire_q.delete();
    @(posedge clk) #1;
    in_valid = 1'b1;
    in_data  = rnd128();
    in_key   = rnd128();
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ir[0]) break;
      end
      check("stream_ready", 128'(ir[0]), 128'd1);
      @(posedge clk) #1;
      if (blk == 7) in_valid = 1'b0;
      else begin
        in_data = rnd128();
        in_key  = rnd128();
      end
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fire_q.size() >= 8) break;
    end
    check("stream_count", 128'(fire_q.size()), 128'd8);
    for (int i = 1; i < fire_q.size(); i++)
      check("stream_period", 128'(fire_q[i] - fire_q[i-1]), 128'd12);
    repeat (5) @(negedge clk);
    check("drain_std", 128'(mon[0].q.size()), 128'd0);
    check("drain_add10", 128'(mon[1].q.size()), 128'd0);
    check("drain_add1", 128'(mon[2].q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
